hps_pio_out_ctrl: RTL and testbench
===================================

Name: hps_pio_out_ctrl

Overview:
- Parametrised Avalon-MM output PIO; successor to the fixed 2-bit clock/reset control register.
- Adds configurable width and reset value, atomic bit-set/bit-clear, timed auto-clearing pulses and registered readback.
- Sits on the HPS lightweight bridge and drives soft reset/enable lines into the NeuralNetwork fabric.

Parameters:
DATA_WIDTH, 2, width of out_port, legal range 1..32
RESET_VALUE, 0, value loaded into the DATA register on reset (DATA_WIDTH bits)
PULSE_CYCLES, 16, length in clk cycles of a PULSE-register pulse, legal range 1..65535

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  2  register select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, qualified by chipselect
read_n  input  1  active-low read strobe, qualified by chipselect
writedata  input  32  write data; bits [31:DATA_WIDTH] ignored
readdata  output  32  registered read data, read latency 1
out_port  output  DATA_WIDTH  DATA | PULSE_MASK
pulse_busy  output  1  high while any pulse bit is active

Behaviour:
- Single clock (clk); reset is synchronous and active-high.
- State registers: data_reg[DATA_WIDTH], pulse_mask[DATA_WIDTH], pulse_cnt[16], readdata[32].
- Reset values: data_reg=RESET_VALUE, pulse_mask=0, pulse_cnt=0, readdata=0.
  - Hence out_port=RESET_VALUE and pulse_busy=0.
  - Reset mid-pulse aborts the pulse on the next edge.
- wr = chipselect & ~write_n. rd = chipselect & ~read_n. wd = writedata[DATA_WIDTH-1:0].
- Write map, applied at the edge where wr=1:
  - addr0 DATA: data_reg <= wd.
  - addr1 SET: data_reg <= data_reg | wd.
  - addr2 CLEAR: data_reg <= data_reg & ~wd.
  - addr3 PULSE, wd!=0: pulse_mask <= pulse_mask | wd; pulse_cnt <= PULSE_CYCLES.
  - addr3 PULSE, wd==0: no effect; no restart of a running pulse.
- Pulse timing:
  - While pulse_cnt!=0 and there is no PULSE write, pulse_cnt decrements each cycle.
  - When pulse_cnt transitions 1->0, pulse_mask <= 0 on the same edge.
  - A PULSE write accepted at edge k drives its bits high on out_port from after edge k through edge k+PULSE_CYCLES: exactly PULSE_CYCLES cycles.
- Retrigger: a PULSE write during an active pulse ORs in the new bits and reloads pulse_cnt. All pending bits are extended, including on the expiry cycle; the write takes priority over the clear.
- out_port = data_reg | pulse_mask (combinational OR of registers).
  - A bit that is set in both stays high after pulse expiry.
  - DATA/SET/CLEAR writes never modify pulse_mask.
- pulse_busy = (pulse_cnt != 0).
- Read map: readdata is updated at the edge where rd=1, so it is valid the cycle after rd. When rd=0, readdata <= 0.
  - addr0: data_reg, zero-extended.
  - addr1: out_port, zero-extended.
  - addr2: pulse_mask, zero-extended.
  - addr3: {pulse_busy, 15'b0, pulse_cnt}.
- Simultaneous read and write in the same cycle: the write is applied, and the read returns pre-write values.
- No wait states. Every access completes in its cycle; no back-pressure.

Test Plan:
- Config for all tests: DATA_WIDTH=8, RESET_VALUE=8'hA5, PULSE_CYCLES=4.
- Reset and readback: assert reset 2 cycles -> out_port=8'hA5, pulse_busy=0. Read addr0 -> readdata=32'h000000A5 one cycle after rd.
- Set/clear atomics: write DATA=8'h0F, SET=8'hF0, CLEAR=8'h3C -> out_port=8'h0F, then 8'hFF, then 8'hC3. Write DATA with writedata=32'hFFFF_FF00 -> out_port=8'h00 (upper bits ignored).
- Pulse length: DATA=0, write PULSE=8'h01 at edge k -> out_port=8'h01 for exactly 4 cycles, 8'h00 after edge k+4. pulse_busy mirrors this. Read addr3 just after the write -> 32'h80000004.
- Retrigger at expiry: PULSE=8'h01 at k, PULSE=8'h02 at k+3 -> out_port=8'h03 from k+4 through edge k+7, 0 after. PULSE=8'h00 mid-pulse -> no extension.
- Overlap with DATA: DATA=8'h01, PULSE=8'h01 -> out_port stays 8'h01 after expiry. Read addr2 after expiry -> 0.
- Reset mid-pulse, plus read during write: reset at k+2 of a pulse -> next cycle out_port=8'hA5, pulse_cnt=0. Simultaneous DATA write 8'h11 and addr0 read -> readdata holds the old value, and the following read returns 8'h11.

Source files
------------

// File: rtl/hps_pio_out_ctrl.sv
// Avalon-MM output PIO with atomic set/clear, timed auto-clearing pulses and
// registered readback; drives soft reset/enable lines into the fabric.
module hps_pio_out_ctrl #(
  parameter int                    DATA_WIDTH   = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PULSE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLEAR = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] pulse_mask;
  logic [15:0]           pulse_cnt;

  logic                  wr;
  logic                  rd;
  logic [DATA_WIDTH-1:0] wd;
  logic                  pulse_wr;
  logic [31:0]           rd_data;
  logic                  unused_wdata;

  assign wr       = chipselect & ~write_n;
  assign rd       = chipselect & ~read_n;
  assign wd       = writedata[DATA_WIDTH-1:0];
  assign pulse_wr = wr && (address == ADDR_PULSE) && (wd != '0);

  // Upper write-data bits beyond DATA_WIDTH are intentionally ignored.
  assign unused_wdata = ^writedata;

  assign out_port   = data_reg | pulse_mask;
  assign pulse_busy = (pulse_cnt != 16'd0);

  // Read mux sees pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_data = 32'd0;
    case (address)
      ADDR_DATA:  rd_data = 32'(data_reg);
      ADDR_SET:   rd_data = 32'(out_port);
      ADDR_CLEAR: rd_data = 32'(pulse_mask);
      ADDR_PULSE: rd_data = {pulse_busy, 15'd0, pulse_cnt};
      default:    rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        ADDR_DATA:  data_reg <= wd;
        ADDR_SET:   data_reg <= data_reg | wd;
        ADDR_CLEAR: data_reg <= data_reg & ~wd;
        default:    data_reg <= data_reg;
      endcase
    end
  end

  // A pulse write wins over the terminal-count clear so retrigger at expiry extends all bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_mask <= '0;
      pulse_cnt  <= 16'd0;
    end else if (pulse_wr) begin
      pulse_mask <= pulse_mask | wd;
      pulse_cnt  <= PULSE_LOAD;
    end else if (pulse_cnt != 16'd0) begin
      pulse_cnt <= pulse_cnt - 16'd1;
      if (pulse_cnt == 16'd1) begin
        pulse_mask <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (rd) begin
      readdata <= rd_data;
    end else begin
      readdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_hps_pio_out_ctrl.sv
// Directed bench for hps_pio_out_ctrl: a vector table for register access
// plus hand-written pulse, retrigger, reset and read-during-write sequences.
module tb_hps_pio_out_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  int n_cmp;
  int n_err;

  hps_pio_out_ctrl #(
    .DATA_WIDTH  (8),
    .RESET_VALUE (8'hA5),
    .PULSE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .read_n    (read_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .pulse_busy(pulse_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  exp_out;
    logic        exp_busy;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] exp_out, input logic exp_busy);
    chk({name, "_out"}, {24'd0, out_port}, {24'd0, exp_out});
    chk({name, "_busy"}, {31'd0, pulse_busy}, {31'd0, exp_busy});
  endtask

  // One bus cycle: drive at negedge, return 1 time unit after the posedge.
  task automatic cycle(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    reset      = 1'b0;
    chipselect = w | r;
    write_n    = ~w;
    read_n     = ~r;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;

    //          wr    rd    addr  wdata          out    busy  readdata
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 8'hA5, 1'b0, 32'h0000_00A5};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h0000_000F, 8'h0F, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0000, 8'h0F, 1'b0, 32'h0000_000F};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 32'h0000_00F0, 8'hFF, 1'b0, 32'h0000_0000};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 32'h0000_003C, 8'hC3, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 8'hC3, 1'b0, 32'h0000_00C3};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FF00, 8'h00, 1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 32'hABCD_0081, 8'h81, 1'b0, 32'h0000_0000};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 8'h81, 1'b0, 32'h0000_0081};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 8'h81, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h0000_0000, 8'h81, 1'b0, 32'h0000_0000};
    vecs[11] = '{1'b0, 1'b1, 2'd3, 32'h0000_0000, 8'h81, 1'b0, 32'h0000_0000};

    reset_cycle();
    reset_cycle();
    chk_out("reset", 8'hA5, 1'b0);
    chk("reset_rd", readdata, 32'd0);

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy);
      chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end

    // Basic pulse: write at edge k, high after k..k+3, low after k+4; addr3 read right after.
    cycle(1'b1, 1'b0, 2'd0, 32'h0);
    cycle(1'b1, 1'b0, 2'd3, 32'h01);
    chk_out("pulse_k0", 8'h01, 1'b1);
    cycle(1'b0, 1'b1, 2'd3, 32'h0);
    chk_out("pulse_k1", 8'h01, 1'b1);
    chk("pulse_cnt_rd", readdata, 32'h8000_0004);
    for (int i = 2; i <= 5; i++) begin
      idle();
      chk_out($sformatf("pulse_k%0d", i), (i < 4) ? 8'h01 : 8'h00, (i < 4));
    end

    // Retrigger at edge k+3: 0x02 joins, both bits held until edge k+7.
    cycle(1'b1, 1'b0, 2'd3, 32'h01);
    idle();
    idle();
    chk_out("retrig_k2", 8'h01, 1'b1);
    cycle(1'b1, 1'b0, 2'd3, 32'h02);
    chk_out("retrig_k3", 8'h03, 1'b1);
    for (int i = 4; i <= 7; i++) begin
      idle();
      chk_out($sformatf("retrig_k%0d", i), (i < 7) ? 8'h03 : 8'h00, (i < 7));
    end

    // Retrigger exactly on the expiry edge k+4: write beats the clear.
    cycle(1'b1, 1'b0, 2'd3, 32'h01);
    for (int i = 1; i <= 3; i++) idle();
    chk_out("exp_k3", 8'h01, 1'b1);
    cycle(1'b1, 1'b0, 2'd3, 32'h02);
    chk_out("exp_k4", 8'h03, 1'b1);
    for (int i = 5; i <= 8; i++) begin
      idle();
      chk_out($sformatf("exp_k%0d", i), (i < 8) ? 8'h03 : 8'h00, (i < 8));
    end

    // Zero-valued PULSE write mid-pulse must not extend it.
    cycle(1'b1, 1'b0, 2'd3, 32'h01);
    idle();
    cycle(1'b1, 1'b0, 2'd3, 32'hFFFF_FF00);
    chk_out("zero_k2", 8'h01, 1'b1);
    idle();
    chk_out("zero_k3", 8'h01, 1'b1);
    idle();
    chk_out("zero_k4", 8'h00, 1'b0);

    // Overlap with DATA: bit stays high after expiry, mask reads back 0.
    cycle(1'b1, 1'b0, 2'd0, 32'h01);
    cycle(1'b1, 1'b0, 2'd3, 32'h01);
    cycle(1'b0, 1'b1, 2'd2, 32'h0);
    chk("ovl_mask_busy", readdata, 32'h0000_0001);
    for (int i = 2; i <= 4; i++) idle();
    chk_out("ovl_after", 8'h01, 1'b0);
    cycle(1'b0, 1'b1, 2'd2, 32'h0);
    chk("ovl_mask_done", readdata, 32'h0);

    // Reset at k+2 of a pulse aborts it.
    cycle(1'b1, 1'b0, 2'd3, 32'h10);
    chk_out("rst_k0", 8'h11, 1'b1);
    idle();
    reset_cycle();
    chk_out("rst_k2", 8'hA5, 1'b0);
    cycle(1'b0, 1'b1, 2'd3, 32'h0);
    chk("rst_cnt_rd", readdata, 32'h0);
    cycle(1'b0, 1'b1, 2'd2, 32'h0);
    chk("rst_mask_rd", readdata, 32'h0);

    // Read during write returns the old value; next read sees the new one.
    cycle(1'b1, 1'b1, 2'd0, 32'h11);
    chk("rdw_old", readdata, 32'h0000_00A5);
    chk_out("rdw", 8'h11, 1'b0);
    cycle(1'b0, 1'b1, 2'd0, 32'h0);
    chk("rdw_new", readdata, 32'h0000_0011);

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
